alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle processor ALU.
- Registers operands on a START pulse, executes the operation, and returns a registered result with a one-cycle DONE pulse.
- Keeps the existing opcode map 0x1–0x9 and adds unsigned divide and remainder.
- Multiply and divide are iterative. Sits between the control unit and register file; the control unit stalls on BUSY.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (≥4).
- OPRN_WIDTH, 6, opcode width in bits (≥4).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- OPRN  input  OPRN_WIDTH  opcode, latched with START.
- OP1  input  DATA_WIDTH  operand 1, latched with START.
- OP2  input  DATA_WIDTH  operand 2, latched with START.
- OUT  output  DATA_WIDTH  result (low half for multiply, quotient for divide).
- OUT_HI  output  DATA_WIDTH  high half of product for multiply; 0 for all other ops.
- ZERO  output  1  OUT == 0, registered together with OUT.
- ERR  output  1  illegal opcode or divide by zero for the current result.
- BUSY  output  1  operation in progress; high from the cycle after START until DONE.
- DONE  output  1  one-cycle pulse; OUT/OUT_HI/ZERO/ERR are valid and held from this cycle.

Behaviour:
- Reset: RST=1 at a clock edge forces state IDLE and clears OUT, OUT_HI, ZERO, ERR, BUSY, DONE to 0. ZERO resets to 0, not 1.
- Reset mid-operation: the operation is abandoned and no DONE is issued.
- States:
  - IDLE: START=1 latches the operands. Opcodes 0x1–0x9, illegal opcodes and divide-by-zero go to FIN. 0x3 goes to MUL. 0xA/0xB with OP2≠0 go to DIV.
  - MUL: shift-add, one bit per cycle, DATA_WIDTH cycles, then FIN.
  - DIV: restoring, one quotient bit per cycle, DATA_WIDTH cycles, then FIN.
  - FIN: writes the result registers and pulses DONE; returns to IDLE next cycle.
- Latency, START edge to DONE high:
  - 1 cycle for single-cycle ops, illegal opcodes and divide-by-zero.
  - DATA_WIDTH+1 cycles for multiply and divide.
- BUSY is high in MUL, DIV and FIN. A START while BUSY=1 is ignored and not queued.
- START may be asserted in the same cycle DONE is high, which is the FIN→IDLE cycle. It is not accepted until the state is IDLE, i.e. the next cycle.
- Operations (all unsigned, modulo 2^DATA_WIDTH):
  - 0x1 add, 0x2 subtract.
  - 0x3 multiply: full 2·DATA_WIDTH product, {OUT_HI,OUT}.
  - 0x4 logical shift right, 0x5 shift left, both by the full OP2 value; OP2 ≥ DATA_WIDTH yields 0.
  - 0x6 AND, 0x7 OR, 0x8 NOR.
  - 0x9 SLT: OUT=1 if OP1<OP2, else 0.
  - 0xA quotient, 0xB remainder.
- Divide by zero: OUT = all ones (0xA) or OP1 (0xB), ERR=1.
- Illegal opcode (0x0, 0xC and above): OUT=0, ZERO=1, ERR=1.
- ERR=0 for every legal, non-faulting result.
- Result registers are updated only in FIN. Outputs hold between DONEs, regardless of input changes.
- Changes to OP1/OP2/OPRN after START do not affect the in-flight operation.

Test Plan:
- Reset with RST=1 for 2 cycles mid-multiply (START OPRN=0x3, OP1=7, OP2=9, RST on cycle 5) → all outputs 0, no DONE pulse, BUSY=0. A following START OPRN=0x1, OP1=15, OP2=3 → DONE 1 cycle later, OUT=18.
- Single-cycle regression for the 0x1–0x9 opcode map:
  - 12−5 → OUT=7.
  - 8>>3 → OUT=1.
  - 9<<2 → OUT=36.
  - 12 AND 3 → OUT=0, ZERO=1.
  - 17 NOR 5 → OUT=0xFFFFFFEA.
  - SLT 14,1 → OUT=0.
  - 1<<40 → OUT=0.
  - Each case: DONE exactly 1 cycle after START, ERR=0.
- Multiply 0xFFFFFFFF×2 → DONE exactly 33 cycles after START, OUT=0xFFFFFFFE, OUT_HI=1. A START pulsed at cycle 10 with OPRN=0x1 is ignored and the result is unchanged.
- Divide and remainder:
  - 100/7 → OUT=14 after 33 cycles; remainder op → OUT=2.
  - 5/0 → DONE after 1 cycle, OUT=0xFFFFFFFF, ERR=1.
  - Remainder 5/0 → OUT=5, ERR=1.
- Illegal opcode 0x00 and 0x0C → OUT=0, ZERO=1, ERR=1, latency 1.
- DATA_WIDTH=8:
  - 200+100 → OUT=44.
  - 15×17 → OUT=0xFF, OUT_HI=0, DONE after 9 cycles.
  - 250/3 → OUT=83.
- Back-to-back: START held continuously → a new operation is accepted the cycle after each DONE, DONE pulses never merge.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; iterative shift-add multiply and restoring divide, single-cycle ops otherwise; ports CLK/RST/START/OPRN/OP1/OP2 in, OUT/OUT_HI/ZERO/ERR/BUSY/DONE out
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic [DATA_WIDTH-1:0] OUT_HI,
  output logic                  ZERO,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [OPRN_WIDTH-1:0] OP_ADD = 1, OP_SUB = 2, OP_MUL = 3, OP_SRL = 4, OP_SLL = 5,
    OP_AND = 6, OP_OR = 7, OP_NOR = 8, OP_SLT = 9, OP_QUO = 10, OP_REM = 11;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t          r_state;
  logic [W-1:0]    r_a, r_h, r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_rem;
  logic [W:0]      w_sum, w_t, w_diff;
  logic [W-1:0]    w_mh, w_ml, w_dr, w_dq, w_dout, w_res;
  logic            w_ge, w_div, w_err;
  // r_h:r_a is the product accumulator for MUL and remainder:dividend shifter for DIV
  always_comb begin
    w_sum  = {1'b0, r_h} + (r_a[0] ? {1'b0, r_b} : '0);
    w_mh   = w_sum[W:1];
    w_ml   = {w_sum[0], r_a[W-1:1]};
    w_t    = {r_h, r_a[W-1]};
    w_diff = w_t - {1'b0, r_b};
    w_ge   = w_t >= {1'b0, r_b};
    w_dr   = w_ge ? w_diff[W-1:0] : w_t[W-1:0];
    w_dq   = {r_a[W-2:0], w_ge};
    w_dout = r_rem ? w_dr : w_dq;
    w_div  = OPRN == OP_QUO || OPRN == OP_REM;
    w_err  = OPRN == '0 || OPRN > OP_REM || (w_div && OP2 == '0);
    // QUO/REM only reach this path on divide by zero
    w_res  = OPRN == OP_ADD ? OP1 + OP2 :
             OPRN == OP_SUB ? OP1 - OP2 :
             OPRN == OP_SRL ? OP1 >> OP2 :
             OPRN == OP_SLL ? OP1 << OP2 :
             OPRN == OP_AND ? OP1 & OP2 :
             OPRN == OP_OR  ? OP1 | OP2 :
             OPRN == OP_NOR ? ~(OP1 | OP2) :
             OPRN == OP_SLT ? {{(W-1){1'b0}}, OP1 < OP2} :
             OPRN == OP_QUO ? '1 :
             OPRN == OP_REM ? OP1 : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_a <= '0;
      r_h <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_rem <= 1'b0;
      OUT <= '0;
      OUT_HI <= '0;
      ZERO <= 1'b0;
      ERR <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        IDLE: if (START) begin
          r_a <= OP1;
          r_b <= OP2;
          r_h <= '0;
          r_cnt <= '0;
          r_rem <= OPRN == OP_REM;
          BUSY <= 1'b1;
          if (OPRN == OP_MUL) r_state <= MUL;
          else if (w_div && OP2 != '0) r_state <= DIV;
          else begin
            r_state <= FIN;
            DONE <= 1'b1;
            OUT <= w_res;
            OUT_HI <= '0;
            ZERO <= w_res == '0;
            ERR <= w_err;
          end
        end
        MUL: begin
          r_h <= w_mh;
          r_a <= w_ml;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= FIN;
            DONE <= 1'b1;
            OUT <= w_ml;
            OUT_HI <= w_mh;
            ZERO <= w_ml == '0;
            ERR <= 1'b0;
          end
        end
        DIV: begin
          r_h <= w_dr;
          r_a <= w_dq;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= FIN;
            DONE <= 1'b1;
            OUT <= w_dout;
            OUT_HI <= '0;
            ZERO <= w_dout == '0;
            ERR <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          BUSY <= 1'b0;
        end
      endcase
    end
  end
endmodule
